dna_search_sequencer: RTL and testbench

Job scheduler in front of the lab5 DNA pattern-search FSM. It buffers search requests (DNA lengths) in a small FIFO and launches them one at a time into the searcher. Each launch uses a ready pulse plus a held dna_length. The sequencer waits for done, guards each job with a watchdog, and returns one result record per job over a valid/ack handshake.

---
 rtl/dna_search_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dna_search_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_search_sequencer.sv
// Job scheduler in front of the DNA pattern-search FSM.
// Requests (DNA lengths) are queued in a small FIFO. Each one is launched
// with a single-cycle start pulse, watched by a watchdog while the searcher
// runs, and answered with one result record over a valid/ack handshake.
module dna_search_sequencer #(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] MAX_LEN = 16'd4096,
    parameter int          TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        job_valid,
    input  logic [15:0] job_length,
    output logic        job_ready,
    output logic        srch_ready,
    output logic [15:0] srch_length,
    input  logic        srch_done,
    input  logic        srch_found,
    input  logic        srch_error,
    output logic        res_valid,
    output logic        res_found,
    output logic        res_error,
    output logic        res_timeout,
    input  logic        res_ack,
    output logic        busy,
    output logic [7:0]  jobs_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_REPORT
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [15:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [15:0]   head;
    logic          head_bad;

    logic [WW-1:0] wd;
    logic [15:0]   len_reg;
    logic          cap_reject;
    logic          cap_done;
    logic          cap_timeout;
    logic          ack_take;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign job_ready = !full;
    assign push      = job_valid && job_ready;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_bad  = (head == 16'd0) || (head > MAX_LEN);

    // Outputs that follow the current state directly; a reset returns
    // state to IDLE, so srch_ready drops at the reset edge itself.
    assign srch_ready  = (state == ST_LAUNCH);
    assign res_valid   = (state == ST_REPORT);
    assign busy        = (state != ST_IDLE) || !empty;
    assign srch_length = len_reg;

    // FIFO storage; holds data only, so it is not reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= job_length;
        end
    end

    // Next-state logic: pop in IDLE, one-cycle launch, wait with watchdog,
    // then hold the result until the consumer acknowledges it.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        cap_reject  = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        ack_take    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_bad) begin
                        cap_reject = 1'b1;
                        state_next = ST_REPORT;
                    end else begin
                        state_next = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // done is tested first so it wins a tie with expiry
                if (srch_done) begin
                    cap_done   = 1'b1;
                    state_next = ST_REPORT;
                end else if (wd == WD_LAST) begin
                    cap_timeout = 1'b1;
                    state_next  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered control: state, FIFO pointers, watchdog, result record
    // and the acknowledged-job counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wd          <= '0;
            len_reg     <= 16'd0;
            res_found   <= 1'b0;
            res_error   <= 1'b0;
            res_timeout <= 1'b0;
            jobs_done   <= 8'd0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                len_reg <= head;
            end
            if (state == ST_LAUNCH) begin
                wd <= '0;
            end else if (state == ST_WAIT) begin
                wd <= wd + 1'b1;
            end
            if (cap_reject) begin
                res_found   <= 1'b0;
                res_error   <= 1'b1;
                res_timeout <= 1'b0;
            end else if (cap_done) begin
                res_found   <= srch_found;
                res_error   <= srch_error;
                res_timeout <= 1'b0;
            end else if (cap_timeout) begin
                res_found   <= 1'b0;
                res_error   <= 1'b0;
                res_timeout <= 1'b1;
            end
            if (ack_take) begin
                jobs_done <= jobs_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dna_search_sequencer.sv
// Bench for dna_search_sequencer: a scripted searcher responder, a launch
// monitor and a result monitor that pops expected records from queues.
module tb_dna_search_sequencer;

    localparam int TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        job_valid;
    logic [15:0] job_length;
    logic        job_ready;
    logic        srch_ready;
    logic [15:0] srch_length;
    logic        srch_done;
    logic        srch_found;
    logic        srch_error;
    logic        res_valid;
    logic        res_found;
    logic        res_error;
    logic        res_timeout;
    logic        res_ack;
    logic        stray_ack;
    logic        busy;
    logic [7:0]  jobs_done;

    int checks = 0;
    int passes = 0;

    logic [2:0]  exp_res_q[$];
    logic [15:0] exp_launch_q[$];
    int          rsp_delay_q[$];
    logic [1:0]  rsp_fe_q[$];

    dna_search_sequencer #(
        .DEPTH  (4),
        .MAX_LEN(16'd4096),
        .TIMEOUT(TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_length (job_length),
        .job_ready  (job_ready),
        .srch_ready (srch_ready),
        .srch_length(srch_length),
        .srch_done  (srch_done),
        .srch_found (srch_found),
        .srch_error (srch_error),
        .res_valid  (res_valid),
        .res_found  (res_found),
        .res_error  (res_error),
        .res_timeout(res_timeout),
        .res_ack    (res_ack | stray_ack),
        .busy       (busy),
        .jobs_done  (jobs_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Queue a job with its expected launch, searcher behaviour and result.
    // delay < 0 means the searcher never answers.
    task automatic push_job(input logic [15:0] len, input int d, input logic f, input logic e);
        int n;
        if (len != 16'd0 && len <= 16'd4096) begin
            exp_launch_q.push_back(len);
            rsp_delay_q.push_back(d);
            rsp_fe_q.push_back({f, e});
            if (d < 0 || d > TMO) exp_res_q.push_back(3'b001);
            else                  exp_res_q.push_back({f, e, 1'b0});
        end else begin
            exp_res_q.push_back(3'b010);
        end
        job_valid  = 1'b1;
        job_length = len;
        n = 0;
        while (!job_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL push_accept: len %0d never accepted within %0d cycles", len, n);
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_res_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL %s: not idle after %0d cycles, pending %0d", name, n, exp_res_q.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_job_ready"},   32'(job_ready),   32'd1);
        chk({tag, "_srch_ready"},  32'(srch_ready),  32'd0);
        chk({tag, "_srch_length"}, 32'(srch_length), 32'd0);
        chk({tag, "_res_valid"},   32'(res_valid),   32'd0);
        chk({tag, "_res_found"},   32'(res_found),   32'd0);
        chk({tag, "_res_error"},   32'(res_error),   32'd0);
        chk({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_jobs_done"},   32'(jobs_done),   32'd0);
    endtask

    // Scripted searcher: answers each launch after its scheduled delay.
    initial begin
        int         d;
        logic [1:0] fe;
        srch_done  = 1'b0;
        srch_found = 1'b0;
        srch_error = 1'b0;
        forever begin
            tick();
            srch_done = 1'b0;
            if (!reset && srch_ready && rsp_delay_q.size() > 0) begin
                d  = rsp_delay_q.pop_front();
                fe = rsp_fe_q.pop_front();
                if (d >= 0) begin
                    for (int i = 0; i < d; i++) begin
                        tick();
                        if (reset) break;
                    end
                    if (!reset) begin
                        srch_done  = 1'b1;
                        srch_found = fe[1];
                        srch_error = fe[0];
                    end
                end
            end
        end
    end

    // Launch monitor: every start pulse must be expected, carry the queued
    // length, and last exactly one cycle.
    initial begin
        logic        prev;
        logic [15:0] e;
        prev = 1'b0;
        forever begin
            tick();
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (prev) begin
                    checks++;
                    if (!srch_ready) passes++;
                    else $display("FAIL launch_pulse_width: srch_ready still 1, required 0");
                end
                if (srch_ready && !prev) begin
                    checks++;
                    if (exp_launch_q.size() == 0) begin
                        $display("FAIL launch_unexpected: srch_ready=1 length %0d, required no launch", srch_length);
                    end else begin
                        e = exp_launch_q.pop_front();
                        if (srch_length === e) passes++;
                        else $display("FAIL launch_length: got %0d expected %0d", srch_length, e);
                    end
                end
                prev = srch_ready;
            end
        end
    end

    // Result monitor: compare each presented record against the queue head,
    // then acknowledge it.
    initial begin
        logic [2:0] e;
        res_ack = 1'b0;
        forever begin
            tick();
            res_ack = 1'b0;
            if (!reset && res_valid) begin
                checks++;
                if (exp_res_q.size() == 0) begin
                    $display("FAIL result_unexpected: got f/e/t %b, required no result",
                             {res_found, res_error, res_timeout});
                end else begin
                    e = exp_res_q.pop_front();
                    if ({res_found, res_error, res_timeout} === e) passes++;
                    else $display("FAIL result: got f/e/t %b expected %b",
                                  {res_found, res_error, res_timeout}, e);
                end
                res_ack = 1'b1;
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        checks++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        int n;
        reset      = 1'b1;
        job_valid  = 1'b0;
        job_length = 16'd0;
        stray_ack  = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // single job, done with found 3 cycles after the start pulse
        push_job(16'd4, 3, 1'b1, 1'b0);
        n = 0;
        while (!srch_ready && n < 20) begin
            tick();
            n++;
        end
        chk("push_to_launch_edges", 32'(n), 32'd1);
        wait_idle("single_drain");
        chk("single_jobs_done", 32'(jobs_done), 32'd1);

        // back-pressure: first job holds the searcher while 2..5 fill the FIFO
        push_job(16'd1, 5, 1'b1, 1'b0);
        for (int i = 2; i <= 5; i++) push_job(16'(i), 2, 1'(i % 2), 1'b0);
        chk("bp_job_ready_full", 32'(job_ready), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        n = 0;
        while (!job_ready && n < 40) begin
            tick();
            n++;
        end
        chk("bp_job_ready_after_pop", 32'(job_ready), 32'd1);
        wait_idle("bp_drain");
        chk("bp_jobs_done", 32'(jobs_done), 32'd6);

        // rejection and length boundaries
        push_job(16'd0, 0, 1'b0, 1'b0);
        push_job(16'd5000, 0, 1'b0, 1'b0);
        push_job(16'd4096, 1, 1'b0, 1'b1);
        push_job(16'd4097, 0, 1'b0, 1'b0);
        wait_idle("reject_drain");
        chk("reject_jobs_done", 32'(jobs_done), 32'd10);
        chk("reject_launches_consumed", 32'(exp_launch_q.size()), 32'd0);

        // acknowledge with no result pending is ignored
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick();
        chk("stray_ack_jobs_done", 32'(jobs_done), 32'd10);
        chk("stray_ack_res_valid", 32'(res_valid), 32'd0);

        // timeout, then the next queued job runs normally
        push_job(16'd7, -1, 1'b0, 1'b0);
        push_job(16'd9, 2, 1'b1, 1'b0);
        n = 0;
        while (!srch_ready && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk("timeout_launch_to_result", 32'(n), 32'(TMO + 1));
        wait_idle("timeout_drain");
        chk("timeout_jobs_done", 32'(jobs_done), 32'd12);

        // done on the final watchdog cycle wins; one cycle later is a timeout
        push_job(16'd3, TMO, 1'b0, 1'b1);
        push_job(16'd6, TMO, 1'b1, 1'b0);
        push_job(16'd2, TMO + 1, 1'b1, 1'b1);
        wait_idle("collision_drain");
        chk("collision_jobs_done", 32'(jobs_done), 32'd15);

        // reset while one job waits and two are queued
        push_job(16'd10, -1, 1'b0, 1'b0);
        push_job(16'd11, 2, 1'b1, 1'b0);
        push_job(16'd12, 2, 1'b1, 1'b0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        exp_res_q.delete();
        exp_launch_q.delete();
        rsp_delay_q.delete();
        rsp_fe_q.delete();
        tick();
        check_reset_values("midreset");
        reset = 1'b0;
        repeat (20) tick();
        chk("post_reset_res_valid", 32'(res_valid), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        push_job(16'd13, 1, 1'b1, 1'b1);
        wait_idle("post_reset_drain");
        chk("post_reset_jobs_done", 32'(jobs_done), 32'd1);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
